// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR filter: one multiplier and one accumulator step through TAPS coefficients
// per sample. Define FIR_FILTER_SAT_EN to saturate the output; otherwise it wraps.
module fir_filter_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned SHIFT  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  x,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [DATA_W-1:0]  y,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      coef_ready
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned ACC_W = PW + AW;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic signed [DATA_W-1:0] r_delay [TAPS];
  logic signed [COEF_W-1:0] r_coef  [TAPS];
  logic signed [PW-1:0]     r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [CNT_W-1:0]  r_cnt;
  logic signed [DATA_W-1:0] r_y;
  logic                     r_out_valid;

  logic                     w_idle;
  logic                     w_last;
  logic                     w_coef_we;
  logic        [AW-1:0]     w_idx;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [DATA_W-1:0] w_y_next;

  assign w_idle     = (r_state == StIdle);
  assign in_ready   = w_idle;
  assign coef_ready = w_idle;
  assign out_valid  = r_out_valid;
  assign y          = r_y;

  assign w_coef_we = coef_wr_en && w_idle && (32'(coef_addr) < TAPS);

  // The product is registered, so the MAC phase runs TAPS+1 cycles; the last one only adds.
  assign w_last = (r_cnt == CNT_W'(TAPS));

  always_comb begin
    w_idx = '0;
    if (r_cnt < CNT_W'(TAPS)) begin
      w_idx = r_cnt[AW-1:0];
    end
  end

  assign w_prod    = $signed(PW'(r_delay[w_idx])) * $signed(PW'(r_coef[w_idx]));
  assign w_acc_sum = r_acc + {{AW{r_prod[PW-1]}}, r_prod};

`ifdef FIR_FILTER_SAT_EN
  logic signed [ACC_W-1:0] w_shifted;
  assign w_shifted = w_acc_sum >>> SHIFT;

  always_comb begin
    w_y_next = w_shifted[DATA_W-1:0];
    if (!(&w_shifted[ACC_W-1:DATA_W-1]) && (|w_shifted[ACC_W-1:DATA_W-1])) begin
      w_y_next = w_shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign w_y_next = DATA_W'(w_acc_sum >>> SHIFT);
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = StMac;
      StMac:   if (w_last) w_state_next = StOut;
      StOut:   if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_delay[k] <= '0;
        r_coef[k]  <= '0;
      end
      r_prod      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Written before the MAC reads it, so a write on the accept edge affects that sample.
      if (w_coef_we) begin
        r_coef[coef_addr] <= coef_data;
      end
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_delay[0] <= x;
            for (int k = 1; k < TAPS; k++) begin
              r_delay[k] <= r_delay[k-1];
            end
            r_acc  <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
          end
        end
        StMac: begin
          r_acc  <= w_acc_sum;
          r_prod <= w_prod;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_y         <= w_y_next;
            r_out_valid <= 1'b1;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Bench for fir_filter_seq: TAPS=4 and TAPS=6 instances (SHIFT=0) driven against a behavioural
// FIR model through scoreboards. Honours FIR_FILTER_SAT_EN for the expected output reduction.
module tb_fir_filter_seq;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] x = '0;
  logic [1:0]         in_valid = '0;
  logic [1:0]         in_ready;
  logic [1:0]         out_valid;
  logic               out_ready = 1'b1;
  logic [1:0]         coef_wr_en = '0;
  logic [1:0]         coef_ready;
  logic [1:0]         coef_addr4 = '0;
  logic [2:0]         coef_addr6 = '0;
  logic signed [15:0] coef_data = '0;
  logic signed [15:0] y4;
  logic signed [15:0] y6;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  longint q4[$];
  longint q6[$];
  int     lat4[$];
  int     lat6[$];
  longint m_d[2][8];
  longint m_h[2][8];
  logic [1:0] ov_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_filter_seq #(.DATA_W(16), .COEF_W(16), .TAPS(4), .SHIFT(0)) u_dut4 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .y(y4), .out_valid(out_valid[0]), .out_ready(out_ready), .coef_wr_en(coef_wr_en[0]),
    .coef_addr(coef_addr4), .coef_data(coef_data), .coef_ready(coef_ready[0])
  );

  fir_filter_seq #(.DATA_W(16), .COEF_W(16), .TAPS(6), .SHIFT(0)) u_dut6 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .y(y6), .out_valid(out_valid[1]), .out_ready(out_ready), .coef_wr_en(coef_wr_en[1]),
    .coef_addr(coef_addr6), .coef_data(coef_data), .coef_ready(coef_ready[1])
  );

  task automatic check(input string tag, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic longint reduce(input longint a);
`ifdef FIR_FILTER_SAT_EN
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
`else
    logic signed [15:0] t;
    t = a[15:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint model_accept(input int sel, input longint xv);
    int     taps = (sel == 0) ? 4 : 6;
    longint acc = 0;
    for (int k = taps - 1; k > 0; k--) m_d[sel][k] = m_d[sel][k-1];
    m_d[sel][0] = xv;
    for (int k = 0; k < taps; k++) acc += m_d[sel][k] * m_h[sel][k];
    return reduce(acc);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        m_d[s][k] = 0;
        m_h[s][k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency is checked on the rising edge of out_valid, the value on the output handshake.
  always @(negedge clk) begin
    if (out_valid[0] && !ov_prev[0]) begin
      if (lat4.size() == 0) check("lat4_unexpected", longint'(out_valid[0]), 0);
      else check("lat4", longint'(cyc - lat4.pop_front()), 5);
    end
    if (out_valid[0] && out_ready) begin
      if (q4.size() == 0) check("y4_unexpected", longint'(out_valid[0]), 0);
      else check("y4", longint'(y4), q4.pop_front());
    end
    if (out_valid[1] && !ov_prev[1]) begin
      if (lat6.size() == 0) check("lat6_unexpected", longint'(out_valid[1]), 0);
      else check("lat6", longint'(cyc - lat6.pop_front()), 7);
    end
    if (out_valid[1] && out_ready) begin
      if (q6.size() == 0) check("y6_unexpected", longint'(out_valid[1]), 0);
      else check("y6", longint'(y6), q6.pop_front());
    end
    ov_prev = out_valid;
  end

  task automatic drive_coef(input int sel, input bit en, input int addr, input int data);
    coef_wr_en[sel] = en;
    coef_data       = 16'(data);
    if (sel == 0) coef_addr4 = addr[1:0];
    else coef_addr6 = addr[2:0];
  endtask

  task automatic wr_coef(input int sel, input int addr, input int data, input bit exp_ready);
    int taps = (sel == 0) ? 4 : 6;
    drive_coef(sel, 1'b1, addr, data);
    @(negedge clk);
    check($sformatf("coef_ready%0d", sel), longint'(coef_ready[sel]), longint'(exp_ready));
    if (exp_ready && addr < taps) m_h[sel][addr] = data;
    tick();
    drive_coef(sel, 1'b0, 0, 0);
  endtask

  // Offers one sample (optionally with a coefficient write on the same edge) until accepted.
  task automatic send(input int sel, input int xv, input bit wr, input int waddr, input int wdata);
    bit     done = 1'b0;
    longint e = 0;
    x            = 16'(xv);
    in_valid[sel] = 1'b1;
    if (wr) drive_coef(sel, 1'b1, waddr, wdata);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready[sel]) begin
        if (wr) m_h[sel][waddr] = wdata;
        e    = model_accept(sel, longint'(x));
        done = 1'b1;
      end
      tick();
    end
    in_valid[sel] = 1'b0;
    drive_coef(sel, 1'b0, 0, 0);
    if (!done) begin
      check("send_timeout", longint'(in_ready[sel]), 1);
    end else if (sel == 0) begin
      q4.push_back(e);
      lat4.push_back(cyc);
    end else begin
      q6.push_back(e);
      lat6.push_back(cyc);
    end
    if (done) begin
      @(negedge clk);
      check($sformatf("busy_in_ready%0d", sel), longint'(in_ready[sel]), 0);
      tick();
    end
  endtask

  task automatic drain();
    int i = 0;
    while ((q4.size() != 0 || q6.size() != 0) && i < 300) begin
      tick();
      i++;
    end
    if (i >= 300) check("drain_timeout", longint'(q4.size() + q6.size()), 0);
    tick();
  endtask

  task automatic load4(input int h0, input int h1, input int h2, input int h3);
    wr_coef(0, 0, h0, 1'b1);
    wr_coef(0, 1, h1, 1'b1);
    wr_coef(0, 2, h2, 1'b1);
    wr_coef(0, 3, h3, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  bp_ok;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_y", longint'(y4), 0);
    check("rst_out_valid", longint'(out_valid[0]), 0);
    check("rst_in_ready", longint'(in_ready[0]), 1);
    check("rst_coef_ready", longint'(coef_ready[0]), 1);
    check("rst_in_ready6", longint'(in_ready[1]), 1);
    tick();

    // Coefficients reset to zero: everything filters to 0; trailing zeros flush the delay line.
    send(0, 50, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0);
    drain();

    load4(1, 2, 3, 4);
    send(0, 100, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0);
    drain();

    for (int i = 0; i < 5; i++) send(0, 100, 0, 0, 0);
    drain();

    load4(16384, 16384, 16384, 16384);
    for (int i = 0; i < 4; i++) send(0, 32767, 0, 0, 0);
    drain();

    // Backpressure: result must hold while out_ready is low and input traffic is ignored.
    load4(1, 2, 3, 4);
    out_ready = 1'b0;
    send(0, 1234, 0, 0, 0);
    bp_ok = 0;
    for (int i = 0; i < 20 && bp_ok == 0; i++) begin
      @(negedge clk);
      if (out_valid[0]) bp_ok = 1;
    end
    check("bp_valid_seen", longint'(out_valid[0]), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      x           = 16'($urandom);
      in_valid[0] = i[0];
      @(negedge clk);
      check("bp_out_valid", longint'(out_valid[0]), 1);
      check("bp_in_ready", longint'(in_ready[0]), 0);
      check("bp_coef_ready", longint'(coef_ready[0]), 0);
      if (q4.size() != 0) check("bp_y_hold", longint'(y4), q4[0]);
    end
    tick();
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    tick();
    @(negedge clk);
    check("bp_release_valid", longint'(out_valid[0]), 0);
    check("bp_release_ready", longint'(in_ready[0]), 1);
    tick();
    send(0, 7, 0, 0, 0);
    drain();

    // A coefficient write during MAC is dropped; on the accept edge it applies to that sample.
    send(0, 10, 0, 0, 0);
    wr_coef(0, 0, 5, 1'b0);
    drain();
    send(0, 10, 1, 0, 5);
    drain();

    // Reset two cycles after accept discards the in-flight result and clears the delay line.
    send(0, 300, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q4.delete();
    lat4.delete();
    model_reset();
    @(negedge clk);
    check("mid_rst_out_valid", longint'(out_valid[0]), 0);
    check("mid_rst_in_ready", longint'(in_ready[0]), 1);
    check("mid_rst_y", longint'(y4), 0);
    tick();
    load4(1, 2, 3, 4);
    send(0, 100, 0, 0, 0);
    drain();

    // Non-power-of-two taps: writes to addresses 6 and 7 must not land anywhere.
    for (int k = 0; k < 6; k++) wr_coef(1, k, k + 1, 1'b1);
    wr_coef(1, 6, 99, 1'b1);
    wr_coef(1, 7, 99, 1'b1);
    send(1, 100, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(1, 0, 0, 0, 0);
    drain();

    check("q4_empty", longint'(q4.size()), 0);
    check("q6_empty", longint'(q6.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
